// File: rtl/chacha_inverse_permutation_if.sv
// Valid/ready bundle around the inverse ChaCha permutation: one input
// channel carrying the permuted state and one output channel carrying the recovered state.
interface chacha_inverse_permutation_if #(
    parameter int WIDTH = 32
);
    // A transfer happens on a rising clk edge where valid && ready. The
    // producer keeps valid and data stable until then. The consumer may
    // drive ready regardless of valid.
    logic                   in_valid;
    logic                   in_ready;
    logic [16*WIDTH-1:0]    in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [16*WIDTH-1:0]    out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/chacha_inverse_permutation.sv
// Iterative inverse of the ChaCha block permutation: undoes one half-round per
// clock, which recovers the state that existed before ROUNDS forward rounds.
module chacha_inverse_permutation #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    chacha_inverse_permutation_if.slave       bus,
    output logic                              busy,
    output logic [1:0]                        state_dbg_o
);
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int SW = 16 * WIDTH;
    localparam logic [CW-1:0] LAST_STEP = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   step_q, step_d;
    logic [SW-1:0]   work_q, work_d;
    logic [SW-1:0]   out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic [SW-1:0]   half_res;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Returns {d, c, b, a}.
    function automatic logic [127:0] inv_qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                            input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        b = ror32(b, 7) ^ c;   c = c - d;   d = ror32(d, 8) ^ a;   a = a - b;
        b = ror32(b, 12) ^ c;  c = c - d;   d = ror32(d, 16) ^ a;  a = a - b;
        return {d, c, b, a};
    endfunction

    // The four quarter rounds of a half-round touch disjoint words, so
    // updating the word array in place is order independent.
    function automatic logic [SW-1:0] half_round(input logic [SW-1:0] s, input logic diag);
        logic [31:0]  w [16];
        logic [127:0] r;
        int ia, ib, ic, id;
        for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
        for (int q = 0; q < 4; q++) begin
            ia = q;
            ib = diag ? 4 + ((q + 1) % 4) : 4 + q;
            ic = diag ? 8 + ((q + 2) % 4) : 8 + q;
            id = diag ? 12 + ((q + 3) % 4) : 12 + q;
            r = inv_qr(w[ia], w[ib], w[ic], w[id]);
            w[ia] = r[31:0];
            w[ib] = r[63:32];
            w[ic] = r[95:64];
            w[id] = r[127:96];
        end
        for (int i = 0; i < 16; i++) half_round[32*i +: 32] = w[i];
    endfunction

    // Even steps undo a diagonal round, odd steps undo a column round.
    assign half_res = half_round(work_q, ~step_q[0]);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        work_d      = work_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_state;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = half_res;
                step_d = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    out_d       = half_res;
                    out_valid_d = 1'b1;
                    step_d      = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            work_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            work_q      <= work_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_q;
    assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_chacha_inverse_permutation.sv
// Directed bench for the inverse ChaCha permutation: RFC 7539 vector, zero state,
// backpressure, back-to-back, mid-run reset and forward/inverse round trips.
module tb_chacha_inverse_permutation;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_a, busy_b;
    logic [1:0] dbg_a, dbg_b;
    int total = 0;
    int bad = 0;
    logic [511:0] exp_q[$];

    chacha_inverse_permutation_if #(.WIDTH(32)) ifa ();
    chacha_inverse_permutation_if #(.WIDTH(32)) ifb ();

    chacha_inverse_permutation #(.WIDTH(32), .ROUNDS(20)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .state_dbg_o(dbg_a)
    );
    chacha_inverse_permutation #(.WIDTH(32), .ROUNDS(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .state_dbg_o(dbg_b)
    );

    always #5 clk = ~clk;

    logic [31:0] rfc_in_w [16] = '{
        32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
        32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
        32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
        32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2};
    logic [31:0] rfc_out_w [16] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    logic [511:0] rfc_in, rfc_out;

    // Forward ChaCha model: column round then diagonal round per double round.
    int qa [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int qb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int qc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int qd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] fwd(input logic [511:0] s, input int rounds);
        logic [31:0] w [16];
        logic [31:0] a, b, c, d;
        for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
        for (int r = 0; r < rounds / 2; r++) begin
            for (int q = 0; q < 8; q++) begin
                a = w[qa[q]]; b = w[qb[q]]; c = w[qc[q]]; d = w[qd[q]];
                a = a + b; d = rol(d ^ a, 16);
                c = c + d; b = rol(b ^ c, 12);
                a = a + b; d = rol(d ^ a, 8);
                c = c + d; b = rol(b ^ c, 7);
                w[qa[q]] = a; w[qb[q]] = b; w[qc[q]] = c; w[qd[q]] = d;
            end
        end
        for (int i = 0; i < 16; i++) fwd[32*i +: 32] = w[i];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers st to instance A, waits for out_valid, then completes the handshake.
    task automatic run_a(input logic [511:0] st, output logic [511:0] res, output int lat,
                         output bit ok);
        int n;
        ifa.in_state = st;
        ifa.in_valid = 1'b1;
        n = 0;
        while (!ifa.in_ready && n < 100) begin step(); n++; end
        step();
        ifa.in_valid = 1'b0;
        lat = 0;
        ok = 1'b0;
        res = '0;
        for (int i = 0; i < 100; i++) begin
            if (ifa.out_valid) begin ok = 1'b1; break; end
            step();
            lat++;
        end
        res = ifa.out_state;
        ifa.out_ready = 1'b1;
        step();
        ifa.out_ready = 1'b0;
    endtask

    task automatic run_b(input logic [511:0] st, output logic [511:0] res, output int lat,
                         output bit ok);
        int n;
        ifb.in_state = st;
        ifb.in_valid = 1'b1;
        n = 0;
        while (!ifb.in_ready && n < 100) begin step(); n++; end
        step();
        ifb.in_valid = 1'b0;
        lat = 0;
        ok = 1'b0;
        res = '0;
        for (int i = 0; i < 100; i++) begin
            if (ifb.out_valid) begin ok = 1'b1; break; end
            step();
            lat++;
        end
        res = ifb.out_state;
        ifb.out_ready = 1'b1;
        step();
        ifb.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ifa.out_valid); end
        total++; if (ifa.out_state !== '0) begin bad++; $display("FAIL reset_out_state got=%h exp=0", ifa.out_state); end
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ifa.in_ready); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        total++; if (dbg_a !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_a); end
        rst = 1'b0;
        step();
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", ifa.in_ready); end
    endtask

    task automatic test_rfc();
        logic [511:0] res;
        int lat;
        bit ok;
        run_a(rfc_in, res, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL rfc_timeout got=no_out_valid exp=out_valid"); end
        total++; if (lat != 20) begin bad++; $display("FAIL rfc_latency got=%0d exp=20", lat); end
        total++; if (res !== rfc_out) begin bad++; $display("FAIL rfc_out_state got=%h exp=%h", res, rfc_out); end
        total++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin
            bad++; $display("FAIL rfc_after_handshake got=ready%b/valid%b exp=ready1/valid0", ifa.in_ready, ifa.out_valid);
        end
    endtask

    task automatic test_zero();
        int cnt;
        bit seen;
        logic [511:0] got;
        ifa.out_ready = 1'b1;
        ifa.in_state = '0;
        ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        cnt = 0;
        seen = 1'b0;
        got = '1;
        for (int i = 0; i < 100; i++) begin
            if (!busy_a) break;
            cnt++;
            if (ifa.out_valid) begin seen = 1'b1; got = ifa.out_state; end
            step();
        end
        ifa.out_ready = 1'b0;
        total++; if (!seen) begin bad++; $display("FAIL zero_seen got=0 exp=1"); end
        total++; if (got !== '0) begin bad++; $display("FAIL zero_out_state got=%h exp=0", got); end
        total++; if (cnt != 21) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=21", cnt); end
    endtask

    task automatic test_backpressure();
        logic [511:0] held;
        logic [511:0] rnd;
        bit ok;
        ifa.out_ready = 1'b0;
        ifa.in_state = rfc_in;
        ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ifa.out_valid) begin ok = 1'b1; break; end
            step();
        end
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=no_out_valid exp=out_valid"); end
        held = ifa.out_state;
        total++; if (held !== rfc_out) begin bad++; $display("FAIL bp_out_state got=%h exp=%h", held, rfc_out); end
        for (int i = 0; i < 7; i++) begin
            for (int w = 0; w < 16; w++) rnd[32*w +: 32] = $urandom;
            ifa.in_state = rnd;
            ifa.in_valid = 1'($urandom_range(0, 1));
            step();
            total++; if (ifa.out_valid !== 1'b1 || ifa.out_state !== rfc_out || ifa.in_ready !== 1'b0 || dbg_a !== 2'd2) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=valid%b/ready%b/st%0d exp=valid1/ready0/st2", i, ifa.out_valid, ifa.in_ready, dbg_a);
            end
        end
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b1;
        step();
        ifa.out_ready = 1'b0;
        total++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=valid%b/ready%b exp=valid0/ready1", ifa.out_valid, ifa.in_ready);
        end
        step();
        total++; if (busy_a !== 1'b0 || ifa.out_state !== rfc_out) begin
            bad++; $display("FAIL bp_single_handshake got=busy%b exp=busy0", busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int acc [2];
        int nacc;
        int nout;
        logic [511:0] exp_v;
        acc[0] = 0; acc[1] = 0;
        nacc = 0;
        nout = 0;
        exp_q.push_back(rfc_out);
        exp_q.push_back('0);
        ifa.out_ready = 1'b1;
        ifa.in_state = rfc_in;
        ifa.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (nacc == 2 && exp_q.size() == 0) break;
            if (ifa.out_valid) begin
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    total++; if (ifa.out_state !== exp_v) begin
                        bad++; $display("FAIL b2b_out%0d got=%h exp=%h", nout, ifa.out_state, exp_v);
                    end
                end
                nout++;
            end
            if (ifa.in_valid && ifa.in_ready && nacc < 2) begin acc[nacc] = i; nacc++; end
            step();
            if (nacc == 1) ifa.in_state = '0;
            if (nacc == 2) ifa.in_valid = 1'b0;
        end
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b0;
        total++; if (nacc != 2 || exp_q.size() != 0 || nout != 2) begin
            bad++; $display("FAIL b2b_counts got=acc%0d/out%0d/left%0d exp=acc2/out2/left0", nacc, nout, exp_q.size());
        end
        total++; if (acc[1] - acc[0] != 22) begin
            bad++; $display("FAIL b2b_accept_gap got=%0d exp=22", acc[1] - acc[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_run();
        logic [511:0] res;
        int lat;
        bit ok;
        ifa.in_state = rfc_in;
        ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        #1;
        total++; if (ifa.out_valid !== 1'b0 || ifa.out_state !== '0 || ifa.in_ready !== 1'b1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL midrun_reset got=valid%b/ready%b/busy%b/st%h exp=valid0/ready1/busy0/st0",
                            ifa.out_valid, ifa.in_ready, busy_a, ifa.out_state[31:0]);
        end
        step();
        rst = 1'b0;
        step();
        run_a(rfc_in, res, lat, ok);
        total++; if (!ok || lat != 20 || res !== rfc_out) begin
            bad++; $display("FAIL midrun_rerun got=ok%0d/lat%0d exp=ok1/lat20 res=%h", ok, lat, res);
        end
    endtask

    task automatic test_round_trip();
        logic [511:0] orig, res;
        int lat;
        bit ok;
        for (int n = 0; n < 1000; n++) begin
            for (int w = 0; w < 16; w++) orig[32*w +: 32] = $urandom;
            run_a(fwd(orig, 20), res, lat, ok);
            total++; if (!ok || lat != 20 || res !== orig) begin
                bad++; $display("FAIL rt20 n=%0d got=%h lat=%0d exp=%h lat=20", n, res, lat, orig);
            end
        end
        for (int n = 0; n < 1000; n++) begin
            for (int w = 0; w < 16; w++) orig[32*w +: 32] = $urandom;
            run_b(fwd(orig, 8), res, lat, ok);
            total++; if (!ok || lat != 8 || res !== orig) begin
                bad++; $display("FAIL rt8 n=%0d got=%h lat=%0d exp=%h lat=8", n, res, lat, orig);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rfc_in[32*i +: 32]  = rfc_in_w[i];
            rfc_out[32*i +: 32] = rfc_out_w[i];
        end
        ifa.in_valid = 1'b0; ifa.in_state = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_state = '0; ifb.out_ready = 1'b0;
        test_reset();
        test_rfc();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chacha_inverse_permutation.md
# chacha_inverse_permutation

Iterative inverse of the ChaCha block permutation. The block accepts a 512-bit state that has been through ROUNDS ChaCha rounds and undoes one half-round per clock, so it recovers the pre-round state. The feed-forward addition is not part of this block. It sits beside the chacha20 core as the decode direction of the quarter-round datapath. Uses: golden-model checks on silicon, and recovery of the input state from a captured permutation output. Valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, word width; only 32 is supported (rotation amounts fixed).
- ROUNDS, 20, number of forward rounds to undo; even, ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_state  in  16*WIDTH  word i at bits [32i+31:32i].
- out_valid  out  1  recovered state available.
- out_ready  in  1  downstream accepts.
- out_state  out  16*WIDTH  recovered state, same packing.
- busy  out  1  state ≠ IDLE.

## Operation
- **Inverse quarter round** on (a,b,c,d), all arithmetic mod 2^32, ror = rotate right:
  - b=ror(b,7)^c; c=c−d; d=ror(d,8)^a; a=a−b;
  - b=ror(b,12)^c; c=c−d; d=ror(d,16)^a; a=a−b.
- **Half-round types.** There are 4 inverse quarter-round instances working in parallel.
  - Inverse diagonal: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
  - Inverse column: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
- **Order.** The forward double round is column then diagonal, so undo runs in reverse order.
  - Step k = 0..ROUNDS−1: even k applies inverse diagonal, odd k applies inverse column.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid: load in_state into the working register, set step counter to 0, go to RUN.
  - RUN: each cycle, replace the working register with its half-round result and increment the step counter. The step with k=ROUNDS−1 commits, the result is loaded into out_state, and the FSM goes to DONE.
  - DONE: out_valid=1 and out_state held stable. When out_valid&&out_ready, go to IDLE. in_valid is ignored in DONE.
- **Input changes.** in_state and in_valid changes during RUN/DONE have no effect.
- **Counter width:** clog2(ROUNDS).
- **Working register:** distinct from the out_state register. out_state changes only on the RUN→DONE transition and on reset.

## Timing
- **Reset (async, immediate):**
  - FSM=IDLE, counter=0, working register=0.
  - out_state=0, out_valid=0, busy=0, in_ready=1.
- **Reset mid-RUN or mid-DONE:** the operation is aborted, nothing is emitted, and the outputs take their reset values.
- **Latency:** input handshake at edge E0; half-rounds at edges E1..E_ROUNDS; out_valid high from E_ROUNDS until the output handshake. That is ROUNDS cycles (20 by default).
- **Throughput:**
  - With out_ready held high: out_valid is high for exactly 1 cycle, the FSM is in IDLE the next cycle, and a new accept is possible then.
  - One block per ROUNDS+2 cycles.
- **Backpressure:** out_valid and out_state are held indefinitely. No output is ever dropped or overwritten.
- **Outputs:** in_ready and busy are decoded combinationally from the FSM state. out_valid and out_state are registered.

## Test plan
- **RFC 7539 §2.3.2 vector** (ROUNDS=20).
  - Stimulus: in_state words 837778ab e238d763 a67ae21e 5950bb2f c4f2d0c7 fc62bb2f 8fa018fc 3f5ec7b7 335271c2 f29489f3 eabda8fc 82e46ebd d19c12b4 b04e16de 9e83d0cb 4e3c50a2.
  - Required response: out_state = 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000.
  - out_valid is high exactly 20 cycles after the accept edge.
- **All-zero state** → out_state all zero; busy high for 21 cycles with out_ready=1.
- **Backpressure.**
  - Stimulus: out_ready low for 7 cycles after out_valid rises, with in_valid toggling and in_state randomised.
  - Required response: out_state stable, in_ready=0, no second accept. After out_ready=1, exactly one handshake occurs, then in_ready=1.
- **Back-to-back.**
  - Stimulus: in_valid held high with two vectors (RFC vector, then zero vector) and out_ready=1.
  - Required response: the second accept occurs 22 cycles after the first; both outputs are correct and in order.
- **Reset mid-RUN.**
  - Stimulus: assert rst at step 9.
  - Required response: out_valid=0, out_state=0, in_ready=1 immediately. A subsequent RFC vector completes correctly.
- **Random round-trip** (ROUNDS=8 and 20).
  - Stimulus: 1000 random states passed through the forward chacha20 rounds model, then fed to this block.
  - Required response: out_state equals the original state every time; latency equals ROUNDS.
